// File: rtl/readback_pkg.sv
// -----------------------------------------------------------------------------
// readback_pkg
//   Shared types and constants for the read-back verifier.
//   - rb_state_t : verifier FSM states (IDLE, CHECK, DONE)
//   - ERR_W      : width of the saturating mismatch counter
// -----------------------------------------------------------------------------
package readback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } rb_state_t;

  localparam int ERR_W = 16;

endpackage

// File: rtl/rb_expect_gen.sv
// -----------------------------------------------------------------------------
// rb_expect_gen
//   Produces the expected word for the next accepted read-back word.
//   The value is SEED after a load and grows by STEP on every advance, so
//   expected[i] = SEED + i*STEP (mod 2^DW) is formed without a multiplier.
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous active-high reset (clears the accumulator)
//   load     in   1    reload SEED (start of a run)
//   advance  in   1    a word was accepted, step to the next expected value
//   expected out  DW   expected value of the current word
// -----------------------------------------------------------------------------
module rb_expect_gen #(
  parameter int          DW   = 16,
  parameter int unsigned SEED = 0,
  parameter int unsigned STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  output logic [DW-1:0] expected
);

  localparam logic [DW-1:0] SEED_W = DW'(SEED);
  localparam logic [DW-1:0] STEP_W = DW'(STEP);

  // Accumulator: load wins over advance so a start in the same cycle as a
  // stray accept still begins the run at SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected <= '0;
    end else if (load) begin
      expected <= SEED_W;
    end else if (advance) begin
      expected <= expected + STEP_W;
    end
  end

endmodule

// File: rtl/readback_verifier.sv
// -----------------------------------------------------------------------------
// readback_verifier
//   Consumes the memory-copy read-back stream, compares every word with the
//   arithmetic pattern SEED + i*STEP, counts words and mismatches, captures
//   the first failure and reports a one-shot verdict.
//
// Optional feature macro: READBACK_CHKSUM_EN
//   When defined, the chksum port exists and accumulates every accepted word
//   (mod 2^16, mismatches included), cleared on start.
//
// Ports
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous active-high reset
//   start          in   1      pulse: clear results and begin a run
//   in_valid       in   1      in_data carries a word this cycle
//   in_data        in   DW     read-back word
//   in_last        in   1      final word marker, qualified by in_valid
//   busy           out  1      high while checking
//   done           out  1      one-cycle verdict strobe
//   pass           out  1      full run, no mismatch, no timeout
//   short_run      out  1      in_last arrived before word DEPTH-1
//   timeout        out  1      run aborted by the idle timer
//   word_cnt       out  CW     words accepted this run
//   err_cnt        out  ERR_W  mismatches (saturating)
//   first_err_idx  out  CW     index of the first mismatch
//   first_err_data out  DW     received word at the first mismatch
//   chksum         out  16     sum of accepted words (READBACK_CHKSUM_EN only)
// -----------------------------------------------------------------------------
module readback_verifier
  import readback_pkg::*;
#(
  parameter int          DW      = 16,
  parameter int          DEPTH   = 16,
  parameter int unsigned SEED    = 0,
  parameter int unsigned STEP    = 1,
  parameter int          TIMEOUT = 32,
  localparam int         CW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             short_run,
  output logic             timeout,
  output logic [CW-1:0]    word_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CW-1:0]    first_err_idx,
  output logic [DW-1:0]    first_err_data
`ifdef READBACK_CHKSUM_EN
  ,
  output logic [15:0]      chksum
`endif
);

  localparam int TW = $clog2(TIMEOUT);

  rb_state_t      state;
  rb_state_t      next_state;
  logic [TW-1:0]  idle_cnt;
  logic [DW-1:0]  expected;
  logic           accept;
  logic           mismatch;
  logic           end_count;
  logic           end_last;
  logic           end_idle;
  logic           finish;

  // start always wins, so a word presented in the start cycle is never taken.
  assign accept    = (state == CHECK) && in_valid && !start;
  assign mismatch  = accept && (in_data != expected);
  assign end_count = accept && (word_cnt == CW'(DEPTH - 1));
  assign end_last  = accept && in_last;
  // The idle counter holds the number of idle cycles already seen, so the
  // TIMEOUT-th consecutive idle cycle is the one where it reads TIMEOUT-1.
  assign end_idle  = (state == CHECK) && !in_valid && !start &&
                     (idle_cnt == TW'(TIMEOUT - 1));
  assign finish    = end_count || end_last || end_idle;

  rb_expect_gen #(
    .DW   (DW),
    .SEED (SEED),
    .STEP (STEP)
  ) u_expect (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .advance  (accept),
    .expected (expected)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start restarts from any state; a run ends on the last
  // expected word, an in_last marker, or the idle timer.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = CHECK;
    end else begin
      case (state)
        CHECK:   if (finish) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  // Counters, first-failure capture, idle timer and verdict flags. Verdict
  // flags are formed from this cycle's word so they are valid together with
  // the done strobe and then hold until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      short_run      <= 1'b0;
      timeout        <= 1'b0;
      word_cnt       <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      idle_cnt       <= '0;
    end else begin
      busy <= (next_state == CHECK);
      done <= finish;
      if (start) begin
        pass           <= 1'b0;
        short_run      <= 1'b0;
        timeout        <= 1'b0;
        word_cnt       <= '0;
        err_cnt        <= '0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        idle_cnt       <= '0;
      end else begin
        if (accept) begin
          word_cnt <= word_cnt + 1'b1;
          idle_cnt <= '0;
          if (mismatch) begin
            // err_cnt never wraps, so zero means no earlier mismatch.
            if (err_cnt == '0) begin
              first_err_idx  <= word_cnt;
              first_err_data <= in_data;
            end
            if (err_cnt != {ERR_W{1'b1}}) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end else if (state == CHECK) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        if (finish) begin
          pass      <= end_count && !mismatch && (err_cnt == '0);
          short_run <= end_last && !end_count;
          timeout   <= end_idle;
        end
      end
    end
  end

`ifdef READBACK_CHKSUM_EN
  // Running sum of every accepted word, mismatching ones included.
  always_ff @(posedge clk) begin
    if (rst) begin
      chksum <= '0;
    end else if (start) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= chksum + 16'(in_data);
    end
  end
`endif

endmodule

// File: tb/tb_readback_verifier.sv
// -----------------------------------------------------------------------------
// tb_readback_verifier
//   Drives directed and random runs into readback_verifier. Each run is a
//   list of per-cycle beats; a reference model walks the list, derives the
//   verdict and the cycle it should appear, and pushes it to a scoreboard.
//   A monitor pops and compares whenever done is seen.
//   Build with READBACK_CHKSUM_EN defined to also check chksum.
// -----------------------------------------------------------------------------
module tb_readback_verifier;

  localparam int          DW      = 16;
  localparam int          DEPTH   = 16;
  localparam int unsigned SEED    = 0;
  localparam int unsigned STEP    = 1;
  localparam int          TIMEOUT = 32;
  localparam int          CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          busy;
  logic          done;
  logic          pass;
  logic          short_run;
  logic          timeout;
  logic [CW-1:0] word_cnt;
  logic [15:0]   err_cnt;
  logic [CW-1:0] first_err_idx;
  logic [DW-1:0] first_err_data;
`ifdef READBACK_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  readback_verifier #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .SEED    (SEED),
    .STEP    (STEP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .short_run      (short_run),
    .timeout        (timeout),
    .word_cnt       (word_cnt),
    .err_cnt        (err_cnt),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
`ifdef READBACK_CHKSUM_EN
    ,
    .chksum         (chksum)
`endif
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; read at negedge by the driver and just
  // after posedge by the monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            v;
    bit            l;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int            wc;
    int            ec;
    int            fidx;
    logic [DW-1:0] fdata;
    bit            pass_f;
    bit            short_f;
    bit            tmo_f;
    logic [15:0]   chk;
    int            cyc;
  } exp_t;

  beat_t beats[$];
  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare the verdict presented with done against the model's prediction.
  task automatic checkOutput(input exp_t e);
    checkEq("done_cycle",     32'(cyc),            32'(e.cyc));
    checkEq("word_cnt",       32'(word_cnt),       32'(e.wc));
    checkEq("err_cnt",        32'(err_cnt),        32'(e.ec));
    checkEq("first_err_idx",  32'(first_err_idx),  32'(e.fidx));
    checkEq("first_err_data", 32'(first_err_data), 32'(e.fdata));
    checkEq("pass",           32'(pass),           32'(e.pass_f));
    checkEq("short_run",      32'(short_run),      32'(e.short_f));
    checkEq("timeout",        32'(timeout),        32'(e.tmo_f));
    checkEq("busy_at_done",   32'(busy),           32'(0));
`ifdef READBACK_CHKSUM_EN
    checkEq("chksum",         32'(chksum),         32'(e.chk));
`endif
  endtask

  task automatic checkZero(input string tag);
    checkEq({tag, "_busy"},      32'(busy),           32'(0));
    checkEq({tag, "_done"},      32'(done),           32'(0));
    checkEq({tag, "_pass"},      32'(pass),           32'(0));
    checkEq({tag, "_short"},     32'(short_run),      32'(0));
    checkEq({tag, "_timeout"},   32'(timeout),        32'(0));
    checkEq({tag, "_word_cnt"},  32'(word_cnt),       32'(0));
    checkEq({tag, "_err_cnt"},   32'(err_cnt),        32'(0));
    checkEq({tag, "_err_idx"},   32'(first_err_idx),  32'(0));
    checkEq({tag, "_err_data"},  32'(first_err_data), 32'(0));
`ifdef READBACK_CHKSUM_EN
    checkEq({tag, "_chksum"},    32'(chksum),         32'(0));
`endif
  endtask

  // Reference model: word i of a run should be SEED + i*STEP; a run ends on
  // word DEPTH, on a valid in_last, or after TIMEOUT consecutive idle cycles.
  task automatic modelRun(output exp_t e, output int end_idx);
    int idx;
    int idle;
    logic [DW-1:0] want;
    idx       = 0;
    idle      = 0;
    end_idx   = -1;
    e.wc      = 0;
    e.ec      = 0;
    e.fidx    = 0;
    e.fdata   = '0;
    e.pass_f  = 1'b0;
    e.short_f = 1'b0;
    e.tmo_f   = 1'b0;
    e.chk     = '0;
    e.cyc     = 0;
    for (int j = 0; j < beats.size(); j++) begin
      if (beats[j].v) begin
        want  = DW'(SEED + idx * STEP);
        e.chk = e.chk + 16'(beats[j].d);
        if (beats[j].d != want) begin
          if (e.ec == 0) begin
            e.fidx  = idx;
            e.fdata = beats[j].d;
          end
          e.ec++;
        end
        idx++;
        idle = 0;
        if (beats[j].l || idx == DEPTH) begin
          e.short_f = (idx < DEPTH);
          end_idx   = j;
          break;
        end
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          e.tmo_f = 1'b1;
          end_idx = j;
          break;
        end
      end
    end
    e.wc     = idx;
    e.pass_f = (idx == DEPTH) && (e.ec == 0) && !e.tmo_f;
  endtask

  function automatic beat_t mkBeat(input bit v, input bit l, input logic [DW-1:0] d);
    beat_t b;
    b.v = v;
    b.l = l;
    b.d = d;
    return b;
  endfunction

  // n correct words, in_last on word last_at (-1 for none), spacing idle
  // cycles between words, then enough idle cycles to guarantee an end.
  task automatic buildDirected(input int n, input int last_at, input int spacing);
    beats.delete();
    for (int k = 0; k < n; k++) begin
      beats.push_back(mkBeat(1'b1, k == last_at, DW'(SEED + k * STEP)));
      if (k < n - 1) repeat (spacing) beats.push_back(mkBeat(1'b0, 1'b0, '0));
    end
    repeat (TIMEOUT + 1) beats.push_back(mkBeat(1'b0, 1'b0, '0));
  endtask

  task automatic buildRandom();
    int n;
    int last_at;
    int r;
    int gap;
    logic [DW-1:0] d;
    beats.delete();
    n       = $urandom_range(0, DEPTH);
    last_at = -1;
    if (n > 0 && $urandom_range(0, 2) != 0) last_at = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 31);
      if (r == 0)      gap = TIMEOUT - 1;
      else if (r == 1) gap = TIMEOUT + 4;
      else             gap = $urandom_range(0, 2);
      repeat (gap) beats.push_back(mkBeat(1'b0, 1'($urandom), DW'($urandom)));
      if ($urandom_range(0, 7) == 0) d = DW'($urandom);
      else                           d = DW'(SEED + i * STEP);
      beats.push_back(mkBeat(1'b1, i == last_at, d));
    end
    repeat (TIMEOUT + 1) beats.push_back(mkBeat(1'b0, 1'($urandom), DW'($urandom)));
  endtask

  // Issue a start, drive the beats up to the predicted end, push the
  // prediction, then drive ignored junk and confirm the results hold.
  task automatic applyStimulus();
    exp_t e;
    int   end_idx;
    modelRun(e, end_idx);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'($urandom);
    in_last  = 1'($urandom);
    in_data  = DW'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= end_idx; j++) begin
      checkEq("busy_in_run", 32'(busy), 32'(1));
      in_valid = beats[j].v;
      in_last  = beats[j].l;
      in_data  = beats[j].d;
      if (j == end_idx) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    repeat (3) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkEq("hold_word_cnt", 32'(word_cnt), 32'(e.wc));
    checkEq("hold_err_cnt",  32'(err_cnt),  32'(e.ec));
    checkEq("hold_pass",     32'(pass),     32'(e.pass_f));
    checkEq("hold_busy",     32'(busy),     32'(0));
  endtask

  // Start a run and feed p correct words that cannot end it; the following
  // start must discard everything.
  task automatic startPartial(input int p);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < p; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = DW'(SEED + k * STEP);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every done must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done=1 with no run ending, required done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst = 1'b0;

    // Traffic in IDLE is ignored.
    repeat (4) begin
      in_valid = 1'b1;
      in_last  = 1'($urandom);
      in_data  = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkZero("idle_ignore");

    // Clean full run.
    buildDirected(DEPTH, DEPTH - 1, 0);
    applyStimulus();

    // Two mismatches, first one captured.
    buildDirected(DEPTH, DEPTH - 1, 0);
    beats[5].d = 16'h0F05;
    beats[9].d = 16'h1234;
    applyStimulus();

    // Words on alternate cycles.
    buildDirected(DEPTH, DEPTH - 1, 1);
    applyStimulus();

    // Early in_last on word 9.
    buildDirected(DEPTH, 9, 0);
    applyStimulus();

    // Four words then silence until the idle timer fires.
    buildDirected(4, -1, 0);
    applyStimulus();

    // Reset in the middle of a run: everything clears, no verdict.
    startPartial(7);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(SEED + 7 * STEP);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    checkZero("mid_reset");
    repeat (4) @(negedge clk);

    // Restart at word 3 of a fresh run, then a clean run.
    startPartial(3);
    buildDirected(DEPTH, DEPTH - 1, 0);
    applyStimulus();

    // Random runs, some preceded by an aborted partial run.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) startPartial($urandom_range(0, DEPTH - 2));
      buildRandom();
      applyStimulus();
    end

    repeat (5) @(negedge clk);
    checkEq("pending_done", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
